// File: rtl/i2c_slave.sv
// I2C target: START/STOP detection, 7-bit address match, byte-wide write/read client interface.
// Define I2C_SLV_STRETCH_EN to hold SCL low on reads until the client acknowledges rd_data.
module i2c_slave #(
   parameter logic [6:0]  SLV_ADDR  = 7'h50,
   parameter int unsigned SETUP_CYC = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       scl_t,
   output logic       sda_t,
   output logic [7:0] wr_data,
   output logic       wr_valid,
   input  logic       wr_ready,
   output logic       rd_req,
   input  logic [7:0] rd_data,
   input  logic       rd_ack,
   output logic       busy,
   output logic [3:0] state
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StAddr     = 3'd1,
      StAddrAck  = 3'd2,
      StWrite    = 3'd3,
      StWriteAck = 3'd4,
      StRead     = 3'd5,
      StRdMack   = 3'd6,
      StIgnore   = 3'd7
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] scl_q, sda_q;  // [1:0] synchronizer, [2] history
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shreg_q, shreg_d, tx_q, tx_d, wr_data_q, wr_data_d;
   logic       byte_done_q, byte_done_d, ack_q, ack_d, sda_t_q, sda_t_d;
   logic       wr_valid_q, wr_valid_d, rd_req_q, rd_req_d, busy_q, busy_d;
   logic       scl_rise, scl_fall, start_det, stop_det, sda_s, load_rd;

   assign sda_s     = sda_q[1];
   assign scl_rise  = scl_q[1] & ~scl_q[2];
   assign scl_fall  = ~scl_q[1] & scl_q[2];
   assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
   assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

`ifdef I2C_SLV_STRETCH_EN
   logic       scl_t_q, scl_t_d, stretch_q, stretch_d, got_ack_q, got_ack_d, data_rdy;
   logic [7:0] setup_q, setup_d;
   assign data_rdy = got_ack_q | rd_ack;
   assign scl_t    = scl_t_q;
`else
   logic       unused_rd_ack;
   logic [7:0] unused_setup;
   assign unused_rd_ack = rd_ack;
   assign unused_setup  = SETUP_CYC[7:0];
   assign scl_t         = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      tx_d        = tx_q;
      wr_data_d   = wr_data_q;
      byte_done_d = byte_done_q;
      ack_d       = ack_q;
      sda_t_d     = sda_t_q;
      busy_d      = busy_q;
      wr_valid_d  = 1'b0;
      rd_req_d    = 1'b0;
      load_rd     = 1'b0;
`ifdef I2C_SLV_STRETCH_EN
      scl_t_d     = scl_t_q;
      stretch_d   = stretch_q;
      setup_d     = setup_q;
      got_ack_d   = rd_ack | (got_ack_q & ~rd_req_q);
`endif
      if (stop_det || start_det) begin
         state_d     = stop_det ? StIdle : StAddr;
         busy_d      = ~stop_det;
         cnt_d       = 3'd0;
         byte_done_d = 1'b0;
         sda_t_d     = 1'b1;
`ifdef I2C_SLV_STRETCH_EN
         scl_t_d     = 1'b1;
         stretch_d   = 1'b0;
         setup_d     = 8'd0;
`endif
      end else begin
         case (state_q)
            StAddr, StWrite: begin
               if (scl_rise) begin
                  shreg_d     = {shreg_q[6:0], sda_s};
                  cnt_d       = cnt_q + 3'd1;
                  byte_done_d = (cnt_q == 3'd7);
                  if (cnt_q == 3'd7 && state_q == StWrite) begin
                     wr_data_d  = {shreg_q[6:0], sda_s};
                     wr_valid_d = 1'b1;
                  end
               end else if (scl_fall && byte_done_q) begin
                  byte_done_d = 1'b0;
                  if (state_q == StWrite) begin
                     ack_d   = wr_ready;
                     sda_t_d = ~wr_ready;
                     state_d = StWriteAck;
                  end else if (shreg_q[7:1] == SLV_ADDR) begin
                     sda_t_d = 1'b0;
                     state_d = StAddrAck;
                  end else begin
                     state_d = StIgnore;
                  end
               end
            end
            StAddrAck: begin
               if (scl_rise && shreg_q[0]) begin
                  rd_req_d = 1'b1;
               end else if (scl_fall) begin
                  cnt_d = 3'd0;
                  if (shreg_q[0]) begin
                     load_rd = 1'b1;
                  end else begin
                     sda_t_d = 1'b1;
                     state_d = StWrite;
                  end
               end
            end
            StWriteAck: begin
               if (scl_fall) begin
                  sda_t_d = 1'b1;
                  cnt_d   = 3'd0;
                  state_d = ack_q ? StWrite : StIgnore;
               end
            end
            StRead: begin
`ifdef I2C_SLV_STRETCH_EN
               if (stretch_q) begin
                  // SCL is held low here; data is set up before the line is released
                  if (setup_q == 8'd0) begin
                     if (data_rdy) begin
                        tx_d    = rd_data;
                        sda_t_d = rd_data[7];
                        setup_d = SETUP_CYC[7:0];
                     end
                  end else begin
                     setup_d = setup_q - 8'd1;
                     if (setup_q == 8'd1) begin
                        scl_t_d   = 1'b1;
                        stretch_d = 1'b0;
                     end
                  end
               end else
`endif
               if (scl_fall) begin
                  if (cnt_q == 3'd7) begin
                     sda_t_d = 1'b1;
                     cnt_d   = 3'd0;
                     state_d = StRdMack;
                  end else begin
                     sda_t_d = tx_q[6];
                     tx_d    = {tx_q[6:0], 1'b0};
                     cnt_d   = cnt_q + 3'd1;
                  end
               end
            end
            StRdMack: begin
               if (scl_rise) begin
                  if (sda_s) state_d = StIgnore;
                  else       rd_req_d = 1'b1;
               end else if (scl_fall) begin
                  cnt_d   = 3'd0;
                  load_rd = 1'b1;
               end
            end
            default: sda_t_d = 1'b1;
         endcase
      end

      if (load_rd) begin
         state_d = StRead;
`ifdef I2C_SLV_STRETCH_EN
         if (!data_rdy) begin
            stretch_d = 1'b1;
            scl_t_d   = 1'b0;
         end else
`endif
         begin
            tx_d    = rd_data;
            sda_t_d = rd_data[7];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         scl_q       <= 3'b111;
         sda_q       <= 3'b111;
         cnt_q       <= 3'd0;
         shreg_q     <= 8'd0;
         tx_q        <= 8'd0;
         wr_data_q   <= 8'd0;
         byte_done_q <= 1'b0;
         ack_q       <= 1'b0;
         sda_t_q     <= 1'b1;
         wr_valid_q  <= 1'b0;
         rd_req_q    <= 1'b0;
         busy_q      <= 1'b0;
`ifdef I2C_SLV_STRETCH_EN
         scl_t_q     <= 1'b1;
         stretch_q   <= 1'b0;
         got_ack_q   <= 1'b0;
         setup_q     <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         scl_q       <= {scl_q[1:0], scl_i};
         sda_q       <= {sda_q[1:0], sda_i};
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         tx_q        <= tx_d;
         wr_data_q   <= wr_data_d;
         byte_done_q <= byte_done_d;
         ack_q       <= ack_d;
         sda_t_q     <= sda_t_d;
         wr_valid_q  <= wr_valid_d;
         rd_req_q    <= rd_req_d;
         busy_q      <= busy_d;
`ifdef I2C_SLV_STRETCH_EN
         scl_t_q     <= scl_t_d;
         stretch_q   <= stretch_d;
         got_ack_q   <= got_ack_d;
         setup_q     <= setup_d;
`endif
      end
   end

   assign sda_t    = sda_t_q;
   assign wr_data  = wr_data_q;
   assign wr_valid = wr_valid_q;
   assign rd_req   = rd_req_q;
   assign busy     = busy_q;
   assign state    = {1'b0, state_q};

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (slave) for the same open-drain bus the I2C master block drives.
- Detects START/STOP and matches a 7-bit address.
- Accepts write bytes from the master and supplies read bytes from user logic over a simple byte interface.
- Sits between the board pads (via tristate buffers) and a register/FIFO client.

Parameters:
- SLV_ADDR, 7'h50, 7-bit bus address the block responds to.
- SETUP_CYC, 4, clocks SDA is held stable before releasing SCL after a stretch (STRETCH build only).

Ports:
- clock  in  1  system clock, ≥10x SCL rate
- reset_n  in  1  asynchronous active-low reset
- scl_i  in  1  SCL pad input
- sda_i  in  1  SDA pad input
- scl_t  out  1  SCL drive: 0 = pull low, 1 = release
- sda_t  out  1  SDA drive: 0 = pull low, 1 = release
- wr_data  out  8  last byte written by master
- wr_valid  out  1  one-cycle pulse, wr_data new
- wr_ready  in  1  client can accept a byte; 0 at ACK slot -> NACK
- rd_req  out  1  one-cycle pulse, next read byte needed
- rd_data  in  8  byte to transmit
- rd_ack  in  1  rd_data valid (used only in STRETCH build)
- busy  out  1  high from START until STOP or reset
- state  out  4  current FSM state (debug)

Behaviour:
- Reset values (async, reset_n=0): scl_t=1, sda_t=1, wr_data=0, wr_valid=0, rd_req=0, busy=0, state=IDLE, bit counter=0.
- Input sync: scl_i/sda_i pass through 2-flop synchronizers plus one history flop. All edge detection uses the synchronized values. Edge-to-action latency is 3 clocks.
- START: synced SDA falls while SCL high. Enter ADDR from any state (repeated START included), clear bit count, release SDA, set busy.
- STOP: synced SDA rises while SCL high. Enter IDLE from any state, release SDA/SCL, clear busy.
- START/STOP detection has priority over bit processing in the same clock.
- Bit timing: sample on SCL rise; change sda_t only on SCL fall. MSB first.
- FSM states and encoding:
  - IDLE=0: wait for START.
  - ADDR=1: shift 8 bits. On the fall after bit 8:
    - addr[7:1]==SLV_ADDR -> sda_t=0 (ACK), go to ADDR_ACK.
    - otherwise -> IGNORE, SDA released.
  - ADDR_ACK=2: on the fall ending the ACK slot:
    - R/W=0 -> release SDA, go to WRITE.
    - R/W=1 -> READ (rd_req was pulsed on the ACK-slot rise; rd_data latched here, MSB driven).
  - WRITE=3: shift 8 bits. On the 8th rise: wr_data updated, wr_valid pulses 1 clock. On the next fall: sda_t = wr_ready ? 0 : 1 (ACK/NACK), go to WRITE_ACK.
  - WRITE_ACK=4: on the fall ending the slot:
    - ACKed -> release SDA, go to WRITE, count=0.
    - NACKed -> IGNORE.
  - READ=5: drive bits 6..0 on successive falls. On the fall after bit 0: release SDA, go to RD_MACK.
  - RD_MACK=6: sample master ACK on rise.
    - SDA=0 -> pulse rd_req; on the following fall latch rd_data, drive MSB, go to READ.
    - SDA=1 (NACK) -> IGNORE.
  - IGNORE=7: SDA released; wait for START/STOP.
- rd_data must be valid from rd_req+1 clock until the next SCL fall (non-STRETCH build).
- Bit counter is 3 bits and wraps 7->0 at byte end. There is no byte-count limit.
- Mid-byte STOP discards the partial byte; no wr_valid is issued.
- A write to a non-ready client is NACKed; the byte is still presented with wr_valid.
- SCL low while the FSM waits is tolerated indefinitely; no timeout.

Optional Feature:
- Macro: I2C_SLV_STRETCH_EN.
- Defined:
  - On the SCL fall that would latch rd_data (ADDR_ACK->READ or RD_MACK->READ), if no rd_ack has been seen since rd_req, hold scl_t=0.
  - On rd_ack=1: latch rd_data, drive MSB, wait SETUP_CYC clocks, then scl_t=1.
  - rd_ack arriving before the fall: no stretch.
- Undefined:
  - scl_t tied to 1; rd_ack ignored.
  - rd_data latched unconditionally on the fall.

Test Plan:
- START, 0xA0, 0x12, 0x34, STOP with wr_ready=1 -> ACK on 3 slots; wr_valid twice with wr_data 0x12 then 0x34; busy falls after STOP.
- START, 0x84 (address 0x42) -> SDA released at ACK slot (NACK); state=7; no wr_valid/rd_req until STOP.
- START, 0xA1, rd_data=0xC3, master NACK, STOP -> ACK; SDA bits 1,1,0,0,0,0,1,1; one rd_req; state IDLE after STOP.
- START, 0xA0, 0x55, repeated START, 0xA1, master ACK then NACK -> wr_valid with 0x55; rd_req twice; state passes 3->1->2->5.
- START, 0xA0, 0x99 with wr_ready=0 -> NACK at data slot; wr_valid pulses with 0x99; state=7.
- STRETCH build: read with rd_ack delayed 200 clocks -> scl_t low ~200 clocks, then SDA=MSB, SCL released SETUP_CYC=4 clocks later; byte received intact.
